// File: rtl/spi_xfer_if.sv
// Control/handshake bundle between the save-controller and the SPI transfer engine.
interface spi_xfer_if #(
    parameter int unsigned CMD_W  = 32,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned CL_W = $clog2(CMD_W + 1);
    localparam int unsigned DL_W = $clog2(DATA_W + 1);

    logic              start;
    logic [CMD_W-1:0]  cmd;
    logic [CL_W-1:0]   cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic [DL_W-1:0]   data_len;
    logic              end_desel;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output start, cmd, cmd_len, wr_data, data_len, end_desel,
        input  busy, done, rd_data
    );

    modport slave (
        input  start, cmd, cmd_len, wr_data, data_len, end_desel,
        output busy, done, rd_data
    );
endinterface

// File: rtl/spi_xfer_engine.sv
// SPI mode-0 master: variable-length command then full-duplex data phase,
// programmable SCLK divider, optional CS retention with HOLD pausing.
module spi_xfer_engine #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CMD_W   = 32,
    parameter int unsigned DATA_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    spi_xfer_if.slave  bus,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_hold_n,
    input  logic       spi_miso
);
    localparam int unsigned CL_W  = $clog2(CMD_W + 1);
    localparam int unsigned DL_W  = $clog2(DATA_W + 1);
    localparam int unsigned CNT_W = $clog2(CMD_W + DATA_W + 1);
    localparam int unsigned DIV_W = 8;

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, DESEL} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [CMD_W-1:0]  cmd_sr;
    logic [DATA_W-1:0] data_sr;
    logic [CL_W-1:0]   cmd_rem;
    logic [CNT_W-1:0]  bits_rem;
    logic              cur_cmd;
    logic              desel_q;

    logic [CL_W-1:0]   cmd_len_c;
    logic [DL_W-1:0]   data_len_c;
    logic [CNT_W-1:0]  total_c;
    logic              div_end;

    // Oversized lengths saturate at the register widths.
    assign cmd_len_c  = (bus.cmd_len  > CL_W'(CMD_W))  ? CL_W'(CMD_W)  : bus.cmd_len;
    assign data_len_c = (bus.data_len > DL_W'(DATA_W)) ? DL_W'(DATA_W) : bus.data_len;
    assign total_c    = CNT_W'(cmd_len_c) + CNT_W'(data_len_c);
    assign div_end    = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            cmd_sr      <= '0;
            data_sr     <= '0;
            cmd_rem     <= '0;
            bits_rem    <= '0;
            cur_cmd     <= 1'b0;
            desel_q     <= 1'b1;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rd_data <= '0;
            spi_cs_n    <= 1'b1;
            spi_sclk    <= 1'b0;
            spi_mosi    <= 1'b0;
            spi_hold_n  <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (total_c == '0) begin
                            bus.done <= 1'b1;
                        end else begin
                            state       <= SHIFT_LO;
                            div_cnt     <= '0;
                            bus.busy    <= 1'b1;
                            bus.rd_data <= '0;
                            spi_cs_n    <= 1'b0;
                            spi_hold_n  <= 1'b1;
                            desel_q     <= bus.end_desel;
                            bits_rem    <= total_c - CNT_W'(1);
                            // First bit goes out immediately; shifters hold what follows it.
                            if (cmd_len_c != '0) begin
                                spi_mosi <= bus.cmd[CMD_W-1];
                                cmd_sr   <= bus.cmd << 1;
                                cmd_rem  <= cmd_len_c - CL_W'(1);
                                cur_cmd  <= 1'b1;
                                data_sr  <= bus.wr_data;
                            end else begin
                                spi_mosi <= bus.wr_data[DATA_W-1];
                                cmd_sr   <= bus.cmd;
                                cmd_rem  <= '0;
                                cur_cmd  <= 1'b0;
                                data_sr  <= bus.wr_data << 1;
                            end
                        end
                    end
                end
                SHIFT_LO: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b1;
                        state    <= SHIFT_HI;
                        if (!cur_cmd) bus.rd_data <= DATA_W'({bus.rd_data, spi_miso});
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b0;
                        if (bits_rem == '0) begin
                            if (desel_q) begin
                                spi_cs_n <= 1'b1;
                                state    <= DESEL;
                            end else begin
                                spi_hold_n <= 1'b0;
                                bus.done   <= 1'b1;
                                bus.busy   <= 1'b0;
                                state      <= IDLE;
                            end
                        end else begin
                            bits_rem <= bits_rem - CNT_W'(1);
                            state    <= SHIFT_LO;
                            if (cmd_rem != '0) begin
                                spi_mosi <= cmd_sr[CMD_W-1];
                                cmd_sr   <= cmd_sr << 1;
                                cmd_rem  <= cmd_rem - CL_W'(1);
                            end else begin
                                spi_mosi <= data_sr[DATA_W-1];
                                data_sr  <= data_sr << 1;
                                cur_cmd  <= 1'b0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DESEL: begin
                    if (div_end) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_xfer_engine.md
# spi_xfer_engine

Parametrised SPI master engine for the save-RAM/flash interface. It replaces the fixed 3-bit-command, 3-bit-read bit-bang sequencer with a start/busy/done-controlled transfer of a variable-length command followed by a variable-length full-duplex data phase. It supports a programmable SCLK rate, optional chip-select retention between transfers, and HOLD-based pausing. It sits between the save-controller logic and the board SPI pins and runs from the internal-oscillator clock domain.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 1..255.
- CMD_W, 32: command shift register width. Command is sent MSB-first from cmd[CMD_W-1].
- DATA_W, 8: data shift register width.
- clk  input  1  system clock (internal oscillator).
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  transfer request; sampled only when busy=0.
- cmd  input  CMD_W  command bits, left-justified.
- cmd_len  input  $clog2(CMD_W+1)  command bit count; values >CMD_W are clamped to CMD_W.
- wr_data  input  DATA_W  write bits, left-justified, sent MSB-first.
- data_len  input  $clog2(DATA_W+1)  data bit count; values >DATA_W are clamped to DATA_W.
- end_desel  input  1  1 = release CS at end; 0 = keep CS low and pause with HOLD.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.
- rd_data  output  DATA_W  captured MISO bits, right-justified.
- spi_cs_n, spi_sclk, spi_mosi, spi_hold_n  output  1  SPI pins (mode 0).
- spi_miso  input  1  SPI data in.

## Operation
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, spi_hold_n=1, busy=0, done=0, rd_data=0. Reset asserted mid-transfer aborts immediately to these values.
- States: IDLE, SHIFT_LO (SCLK low), SHIFT_HI (SCLK high), DESEL (CS-high gap).
- IDLE + start:
  - Latch cmd, wr_data, end_desel and clamped lengths.
  - N = cmd_len + data_len.
  - If N=0: no pin activity; done pulses next cycle; rd_data unchanged.
  - Otherwise: busy=1, spi_cs_n=0, spi_hold_n=1, rd_data cleared to 0, spi_mosi = first bit; go to SHIFT_LO.
- Bit order: cmd_len command bits first, then data_len bits of wr_data. During the data phase, MISO is sampled on each SCLK rising edge and shifted into rd_data at LSB. MISO is ignored during the command phase.
- spi_mosi changes only while spi_sclk is low (on the falling-edge cycle, or at start). After the last bit, MOSI holds the last value until the next start.
- start while busy=1 is ignored. Inputs are not re-sampled mid-transfer.
- End of transfer with end_desel=1:
  - spi_cs_n=1, spi_hold_n=1.
  - DESEL lasts CLK_DIV cycles, then done=1, busy=0.
- End of transfer with end_desel=0:
  - spi_cs_n stays 0, spi_hold_n=0, done=1, busy=0 in the same cycle.
  - The next accepted start drives spi_hold_n=1 and continues on the same CS assertion.
  - rst or an end_desel=1 transfer releases CS.
- Bit-count arithmetic: counters are wide enough for CMD_W+DATA_W; no wrap.

## Timing
- k = clk cycles after the start-accept edge, with outputs observed in cycle k. At k=0: cs_n=0, mosi=bit0, busy=1.
- For bit i (0..N-1):
  - spi_sclk rises at k = CLK_DIV*(2i+1); MISO is sampled on that edge.
  - spi_sclk falls and mosi = bit i+1 at k = CLK_DIV*(2i+2).
- Completion with end_desel=0: done at k = 2*CLK_DIV*N.
- Completion with end_desel=1: cs_n rises at k = 2*CLK_DIV*N; done at k = 2*CLK_DIV*N + CLK_DIV.
- rd_data is final when done=1 and holds until the next accepted start.
- Earliest next start is accepted on the cycle done=1 (busy=0).

## Test plan
- CLK_DIV=2, cmd=0xA0000000, cmd_len=3, wr_data=0x40, data_len=3, end_desel=1, MISO driven 1,0,1 on data rising edges:
  - MOSI bits 1,0,1,0,1,0 and 6 SCLK pulses.
  - cs_n rises at k=24, done at k=26.
  - rd_data=0x05.
- cmd_len=0, data_len=0, start -> done pulse next cycle; cs_n stays 1; no SCLK edges; busy never 1.
- Transfer A with end_desel=0, then transfer B with end_desel=1:
  - cs_n stays 0 across both; hold_n=0 between A and B, 1 during B.
  - cs_n=1 after B.
- rst asserted at k=7 of a 16-bit transfer -> same-cycle cs_n=1, sclk=0, busy=0, rd_data=0; no done pulse.
- start pulsed at k=5 during a transfer -> ignored; exactly N SCLK pulses; a single done.
- cmd_len=40 with CMD_W=32, data_len=0 -> exactly 32 SCLK pulses; done at k = 2*CLK_DIV*32 + CLK_DIV.
